// File: rtl/corefifo_sync_flush_ctrl_if.sv
// Handshake bundle between FIFO control, the pointer synchronizer chain and the
// flush/qualify sequencer. timeout_err exists only with COREFIFO_SYNC_TIMEOUT_EN.
interface corefifo_sync_flush_ctrl_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 flush_req;
    logic                 flush_ack;
    logic                 sync_srstn;
    logic [ADDRWIDTH:0]   sync_in;
    logic [ADDRWIDTH:0]   ptr_out;
    logic                 ptr_valid;
    logic                 busy;
`ifdef COREFIFO_SYNC_TIMEOUT_EN
    logic                 timeout_err;

    modport master (
        output flush_req, sync_in,
        input  flush_ack, sync_srstn, ptr_out, ptr_valid, busy, timeout_err
    );
    modport slave (
        input  flush_req, sync_in,
        output flush_ack, sync_srstn, ptr_out, ptr_valid, busy, timeout_err
    );
`else
    modport master (
        output flush_req, sync_in,
        input  flush_ack, sync_srstn, ptr_out, ptr_valid, busy
    );
    modport slave (
        input  flush_req, sync_in,
        output flush_ack, sync_srstn, ptr_out, ptr_valid, busy
    );
`endif
endinterface

// File: rtl/corefifo_sync_flush_ctrl.sv
// Clears and refills a gray-pointer synchronizer chain, then qualifies its output as stable.
// Optional settle timeout with sticky error flag: define COREFIFO_SYNC_TIMEOUT_EN.
module corefifo_sync_flush_ctrl #(
    parameter int ADDRWIDTH      = 3,
    parameter int NUM_STAGES     = 2,
    parameter int CLR_CYCLES     = 4,
    parameter int STABLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       srst,
    corefifo_sync_flush_ctrl_if.slave  bus,
    output logic [1:0]                 o_dbg_state
);
    localparam int M1   = (CLR_CYCLES > NUM_STAGES + 1) ? CLR_CYCLES : NUM_STAGES + 1;
    localparam int M2   = (M1 > STABLE_CYCLES) ? M1 : STABLE_CYCLES;
    localparam int MAXC = (M2 > TIMEOUT_CYCLES) ? M2 : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] FILL_LAST = CW'(NUM_STAGES);
    localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_FILL   = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [ADDRWIDTH:0] r_prev;
    logic               r_pending;
    logic               r_sync_srstn;
    logic [ADDRWIDTH:0] r_ptr_out;
    logic               r_ptr_valid;
    logic               r_flush_ack;
    logic               r_busy;

    logic               w_match;
    logic               w_stable_done;
    logic               w_tmo_done;
    logic               w_entering_run;
    logic               w_sync_srstn_nxt;
    logic [ADDRWIDTH:0] w_ptr_nxt;
    logic               w_ptr_valid_nxt;
    logic               w_ack_nxt;
    logic               w_busy_nxt;
    logic               w_pending_nxt;

    assign w_match       = (bus.sync_in == r_prev);
    assign w_stable_done = (r_state == S_SETTLE) && w_match && (r_cnt == STB_LAST);

`ifdef COREFIFO_SYNC_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_tmo_cnt;
    logic [CW-1:0] w_tmo_nxt;
    logic          r_timeout_err;
    logic          w_timeout_err_nxt;

    // Stability wins over the timeout when both land on the same edge.
    assign w_tmo_done = (r_state == S_SETTLE) && !w_stable_done && (r_tmo_cnt == TMO_LAST);

    always_comb begin
        w_tmo_nxt = '0;
        if ((r_state == S_SETTLE) && (w_state_nxt == S_SETTLE))
            w_tmo_nxt = (r_tmo_cnt == TMO_LAST) ? r_tmo_cnt : r_tmo_cnt + CW'(1);
    end

    always_comb begin
        w_timeout_err_nxt = r_timeout_err;
        if (bus.flush_req)
            w_timeout_err_nxt = 1'b0;
        else if (w_tmo_done)
            w_timeout_err_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_tmo_cnt     <= w_tmo_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign bus.timeout_err = r_timeout_err;
`else
    assign w_tmo_done = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= S_CLEAR;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_pending    <= 1'b0;
            r_sync_srstn <= 1'b0;
            r_ptr_out    <= '0;
            r_ptr_valid  <= 1'b0;
            r_flush_ack  <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_prev       <= bus.sync_in;
            r_pending    <= w_pending_nxt;
            r_sync_srstn <= w_sync_srstn_nxt;
            r_ptr_out    <= w_ptr_nxt;
            r_ptr_valid  <= w_ptr_valid_nxt;
            r_flush_ack  <= w_ack_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next state; cnt doubles as the SETTLE run-length of equal samples
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == CLR_LAST) begin
                    w_state_nxt = S_FILL;
                    w_cnt_nxt   = '0;
                end
            end
            S_FILL: begin
                if (r_cnt == FILL_LAST) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_SETTLE: begin
                if (w_stable_done || w_tmo_done) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else if (!w_match) begin
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
        if (bus.flush_req) begin
            w_state_nxt = S_CLEAR;
            w_cnt_nxt   = '0;
        end
    end

    // Output next values, all derived from the upcoming state
    always_comb begin
        w_entering_run   = (w_state_nxt == S_RUN) && (r_state != S_RUN);
        w_sync_srstn_nxt = (w_state_nxt != S_CLEAR);
        w_ptr_valid_nxt  = (w_state_nxt == S_RUN);
        w_busy_nxt       = (w_state_nxt != S_RUN);
        w_ptr_nxt        = (w_state_nxt == S_RUN) ? bus.sync_in : r_ptr_out;
        w_ack_nxt        = w_entering_run && r_pending;
        w_pending_nxt    = r_pending;
        if (bus.flush_req)
            w_pending_nxt = 1'b1;
        else if (w_entering_run)
            w_pending_nxt = 1'b0;
    end

    assign bus.sync_srstn = r_sync_srstn;
    assign bus.ptr_out    = r_ptr_out;
    assign bus.ptr_valid  = r_ptr_valid;
    assign bus.flush_ack  = r_flush_ack;
    assign bus.busy       = r_busy;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_corefifo_sync_flush_ctrl.sv
// Bench for corefifo_sync_flush_ctrl: vector table for power-up and RUN flush,
// hand sequences for settle glitches, nested flushes, mid-sequence reset and timeout.
module tb_corefifo_sync_flush_ctrl;
  logic clk = 1'b0;
  logic srst;
  logic [1:0] dbg_state;

  corefifo_sync_flush_ctrl_if #(.ADDRWIDTH(3)) bus ();

  corefifo_sync_flush_ctrl #(
    .ADDRWIDTH(3), .NUM_STAGES(2), .CLR_CYCLES(4), .STABLE_CYCLES(3), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .srst(srst), .bus(bus), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         srst;
    bit         req;
    logic [3:0] sin;
    logic [7:0] exp;
  } vec_t;

  vec_t       tbl[28];
  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ack_cnt = 0;

  // expected word {sync_srstn, ptr_valid, busy, flush_ack, ptr_out}
  function automatic logic [7:0] ew(int o, int v_at, logic [3:0] pre, logic [3:0] nw, bit ack_en);
    logic [7:0] w;
    w = {(o >= 4) ? 1'b1 : 1'b0, (o >= v_at) ? 1'b1 : 1'b0, (o < v_at) ? 1'b1 : 1'b0,
         (ack_en && o == v_at) ? 1'b1 : 1'b0, (o >= v_at) ? nw : pre};
    return w;
  endfunction

  task automatic check(input string tag);
    logic [7:0] e;
    logic [7:0] a;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, got srstn=%b valid=%b busy=%b ack=%b ptr=%h",
               tag, bus.sync_srstn, bus.ptr_valid, bus.busy, bus.flush_ack, bus.ptr_out);
      return;
    end
    e = exp_q.pop_front();
    a = {bus.sync_srstn, bus.ptr_valid, bus.busy, bus.flush_ack, bus.ptr_out};
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got srstn=%b valid=%b busy=%b ack=%b ptr=%h exp srstn=%b valid=%b busy=%b ack=%b ptr=%h (state=%0d)",
               tag, $time, a[7], a[6], a[5], a[4], a[3:0], e[7], e[6], e[5], e[4], e[3:0], dbg_state);
    end
  endtask

  task automatic drive(input string tag, input bit s, input bit r, input logic [3:0] sin,
                       input logic [7:0] e);
    srst          = s;
    bus.flush_req = r;
    bus.sync_in   = sin;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (bus.flush_ack === 1'b1) ack_cnt++;
    check(tag);
  endtask

  task automatic seq(input string tag, input int o, input bit r, input logic [3:0] sin,
                     input int v_at, input logic [3:0] pre, input logic [3:0] nw, input bit ack_en);
    drive(tag, 1'b0, r, sin, ew(o, v_at, pre, nw, ack_en));
  endtask

  task automatic cmp_bit(input string tag, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b exp %b", tag, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int a0;
    srst = 1'b1;
    bus.flush_req = 1'b0;
    bus.sync_in = 4'h0;

    // power-up (3 reset cycles, sync_in=5) then a single RUN flush with sync_in=9
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      tbl[idx] = '{1'b1, 1'b0, 4'h5, 8'b0010_0000};
      idx++;
    end
    for (int o = 1; o <= 12; o++) begin
      tbl[idx] = '{1'b0, 1'b0, 4'h5, ew(o, 10, 4'h0, 4'h5, 1'b0)};
      idx++;
    end
    tbl[idx] = '{1'b0, 1'b1, 4'h9, ew(0, 10, 4'h5, 4'h9, 1'b1)};
    idx++;
    for (int o = 1; o <= 12; o++) begin
      tbl[idx] = '{1'b0, 1'b0, 4'h9, ew(o, 10, 4'h5, 4'h9, 1'b1)};
      idx++;
    end
    for (int i = 0; i < 28; i++)
      drive((i < 15) ? "powerup" : "run_flush", tbl[i].srst, tbl[i].req, tbl[i].sin, tbl[i].exp);

    // settle with glitching input: 3/6 toggles on edges 8..12, stable 6 afterwards
    for (int o = 0; o <= 17; o++)
      seq("settle_glitch", o, o == 0, (o >= 8 && o <= 12 && o % 2 == 0) ? 4'h3 : 4'h6,
          16, 4'h9, 4'h6, 1'b1);

    // nested flushes in FILL and SETTLE: one ack at the final RUN entry
    a0 = ack_cnt;
    for (int o = 0; o <= 4; o++) seq("nest_fill", o, o == 0, 4'hA, 10, 4'h6, 4'hA, 1'b1);
    seq("nest_fill_req", 0, 1'b1, 4'hA, 10, 4'h6, 4'hA, 1'b1);
    for (int o = 1; o <= 7; o++) seq("nest_settle", o, 1'b0, 4'hA, 10, 4'h6, 4'hA, 1'b1);
    seq("nest_settle_req", 0, 1'b1, 4'hA, 10, 4'h6, 4'hA, 1'b1);
    for (int o = 1; o <= 11; o++) seq("nest_final", o, 1'b0, 4'hA, 10, 4'h6, 4'hA, 1'b1);
    n_cmp++;
    if (ack_cnt - a0 != 1) begin
      n_bad++;
      $display("FAIL nest_ack_count: got %0d exp 1", ack_cnt - a0);
    end

    // reset in the middle of SETTLE; pending request must not survive reset
    for (int o = 0; o <= 7; o++) seq("srst_pre", o, o == 0, 4'hB, 10, 4'hA, 4'hB, 1'b1);
    drive("srst_mid", 1'b1, 1'b0, 4'hB, 8'b0010_0000);
    for (int o = 1; o <= 11; o++) seq("srst_restart", o, 1'b0, 4'hB, 10, 4'h0, 4'hB, 1'b0);

`ifdef COREFIFO_SYNC_TIMEOUT_EN
    // toggling input forces the timeout after 8 SETTLE cycles
    for (int o = 0; o <= 15; o++) begin
      seq("timeout", o, o == 0, (o % 2 == 1) ? 4'h3 : 4'h6, 15, 4'hB, 4'h3, 1'b1);
      if (o == 14) cmp_bit("timeout_err_before", bus.timeout_err, 1'b0);
    end
    cmp_bit("timeout_err_set", bus.timeout_err, 1'b1);
    drive("timeout_run", 1'b0, 1'b0, 4'h6, 8'b1100_0110);
    cmp_bit("timeout_err_sticky", bus.timeout_err, 1'b1);
    drive("timeout_flush", 1'b0, 1'b1, 4'h6, 8'b0010_0110);
    cmp_bit("timeout_err_clear", bus.timeout_err, 1'b0);
`else
    // without a timeout, a toggling input keeps SETTLE waiting indefinitely
    for (int o = 0; o <= 34; o++)
      seq("no_timeout", o, o == 0, (o <= 30) ? ((o % 2 == 1) ? 4'h3 : 4'h6) : 4'h6,
          33, 4'hB, 4'h6, 1'b1);
`endif

    cmp_bit("scoreboard_drained", exp_q.size() == 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
